// File: rtl/rename_regfile_np.sv
// rename_regfile_np
//   Architectural register file carrying register-renaming state, with N_RD
//   combinational read channels. Sits between dispatch (reads, rename) and the
//   reorder buffer (commit, flush, producer-tag lookup). x0 is hardwired to zero.
//
//   Parameters
//     XLEN   data width
//     NREG   architectural register count (power of 2)
//     TAG_W  ROB tag width
//     N_RD   number of read channels; channel i uses slice [i*W +: W] of each bus
//
//   Ports
//     clk_in, rst_in        clock, asynchronous active-low reset
//     rdy_in                0 freezes all state; reads stay live
//     flush_in              clears every busy flag, tag and the busy count
//     ren_*                 rename: destination register gets producer ren_tag
//     cmt_*                 commit from ROB head: value write and busy release
//     rd_reg                per-channel read register index
//     rd_val/rd_busy/rd_tag per-channel operand value, pending flag, producer tag
//     rob_q_tag             per-channel stored producer tag, used to query the ROB
//     rob_q_ready/rob_q_val per-channel ROB answer for rob_q_tag
//     busy_cnt              number of registers currently marked busy
module rename_regfile_np #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int N_RD  = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         ren_valid,
  input  logic [$clog2(NREG)-1:0]      ren_reg,
  input  logic [TAG_W-1:0]             ren_tag,
  input  logic                         cmt_valid,
  input  logic [$clog2(NREG)-1:0]      cmt_reg,
  input  logic [TAG_W-1:0]             cmt_tag,
  input  logic [XLEN-1:0]              cmt_val,
  input  logic [N_RD*$clog2(NREG)-1:0] rd_reg,
  output logic [N_RD*XLEN-1:0]         rd_val,
  output logic [N_RD-1:0]              rd_busy,
  output logic [N_RD*TAG_W-1:0]        rd_tag,
  output logic [N_RD*TAG_W-1:0]        rob_q_tag,
  input  logic [N_RD-1:0]              rob_q_ready,
  input  logic [N_RD*XLEN-1:0]         rob_q_val,
  output logic [$clog2(NREG):0]        busy_cnt
);

  localparam int REG_AW = $clog2(NREG);
  localparam logic [REG_AW:0] CNT_ONE = 1;

  logic [XLEN-1:0]  r_regs [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;
  logic [REG_AW:0]  r_busy_cnt;

  logic w_cmt_wr;
  logic w_cmt_clr;
  logic w_ren_do;
  logic w_cnt_inc;
  logic w_cnt_dec;

  assign w_cmt_wr = cmt_valid && (cmt_reg != '0);

  // A rename of the same register in this cycle keeps the register busy under
  // the new producer, so the commit must not release it.
  assign w_cmt_clr = w_cmt_wr && r_busy[cmt_reg] && (r_tag[cmt_reg] == cmt_tag)
                     && !(ren_valid && (ren_reg == cmt_reg));

  assign w_ren_do  = ren_valid && (ren_reg != '0) && !flush_in;
  assign w_cnt_inc = w_ren_do && !r_busy[ren_reg];
  assign w_cnt_dec = w_cmt_clr;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= '0;
        r_tag[k]  <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else if (rdy_in) begin
      // The committed value lands even in a flush cycle.
      if (w_cmt_wr) begin
        r_regs[cmt_reg] <= cmt_val;
      end
      if (flush_in) begin
        for (int k = 0; k < NREG; k++) begin
          r_tag[k] <= '0;
        end
        r_busy     <= '0;
        r_busy_cnt <= '0;
      end else begin
        if (w_cmt_clr) begin
          r_busy[cmt_reg] <= 1'b0;
          r_tag[cmt_reg]  <= '0;
        end
        if (w_ren_do) begin
          r_busy[ren_reg] <= 1'b1;
          r_tag[ren_reg]  <= ren_tag;
        end
        case ({w_cnt_inc, w_cnt_dec})
          2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
          2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
          default: r_busy_cnt <= r_busy_cnt;
        endcase
      end
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [REG_AW-1:0] w_r;
    logic [XLEN-1:0]   w_val;
    logic              w_busy;
    logic [TAG_W-1:0]  w_tag;

    assign w_r = rd_reg[gi*REG_AW +: REG_AW];

    // Reads serve the next instruction, so a rename in this cycle takes
    // precedence over anything already stored or completing. Outputs are
    // forced quiet while reset is asserted.
    always_comb begin
      w_val  = '0;
      w_busy = 1'b0;
      w_tag  = '0;
      if (rst_in && (w_r != '0)) begin
        if (ren_valid && (ren_reg == w_r)) begin
          w_busy = 1'b1;
          w_tag  = ren_tag;
        end else if (r_busy[w_r] && cmt_valid && (cmt_tag == r_tag[w_r])) begin
          w_val = cmt_val;
        end else if (r_busy[w_r] && rob_q_ready[gi]) begin
          w_val = rob_q_val[gi*XLEN +: XLEN];
        end else if (r_busy[w_r]) begin
          w_busy = 1'b1;
          w_tag  = r_tag[w_r];
        end else begin
          w_val = r_regs[w_r];
        end
      end
    end

    assign rd_val[gi*XLEN +: XLEN]     = w_val;
    assign rd_busy[gi]                 = w_busy;
    assign rd_tag[gi*TAG_W +: TAG_W]    = w_tag;
    assign rob_q_tag[gi*TAG_W +: TAG_W] = r_tag[w_r];
  end

endmodule
